// File: rtl/axi4_burst_master.sv
// rtl/axi4_burst_master.sv - single-outstanding AXI4 INCR burst master (optional macro BOUNDARY_CHECK_EN: 4KB-crossing commands complete with SLVERR and issue no AXI traffic)
module axi4_burst_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              ACLK,
    input  logic              ARESET,
    // command
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    // write data stream in
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    // read data stream out
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    input  logic              rd_ready,
    // completion
    output logic              done,
    output logic [1:0]        resp,
    output logic              len_err,
    // AXI4 write address
    output logic [ADDR_W-1:0] AWADDR,
    output logic [LEN_W-1:0]  AWLEN,
    output logic [2:0]        AWSIZE,
    output logic              AWVALID,
    input  logic              AWREADY,
    // AXI4 write data
    output logic [DATA_W-1:0] WDATA,
    output logic              WVALID,
    output logic              WLAST,
    input  logic              WREADY,
    // AXI4 write response
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,
    // AXI4 read address
    output logic [ADDR_W-1:0] ARADDR,
    output logic [LEN_W-1:0]  ARLEN,
    output logic [2:0]        ARSIZE,
    output logic              ARVALID,
    input  logic              ARREADY,
    // AXI4 read data
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    input  logic              RLAST,
    output logic              RREADY
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_AR   = 3'd4;
    localparam logic [2:0] S_R    = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam int         BYTES_LOG = $clog2(DATA_W / 8);
    localparam logic [2:0] AXSIZE    = 3'(BYTES_LOG);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat;
    logic [1:0]        racc;
    logic              over_q;

    logic              w_fire;
    logic              r_fire;
    logic              beat_at_len;
    logic [1:0]        rresp_max;

    assign w_fire      = WVALID & WREADY;
    assign r_fire      = RVALID & RREADY;
    assign beat_at_len = (beat == len_q);
    // worst response seen so far in the read burst, including the current beat
    assign rresp_max   = (RRESP > racc) ? RRESP : racc;

`ifdef BOUNDARY_CHECK_EN
    localparam int SPAN_W = 13 + LEN_W + BYTES_LOG;
    logic [SPAN_W-1:0] span_end;
    logic              crosses_4k;
    assign span_end   = SPAN_W'(cmd_addr[11:0]) + ((SPAN_W'(cmd_len) + SPAN_W'(1)) << BYTES_LOG);
    assign crosses_4k = (span_end > SPAN_W'(4096));
`endif

    // address/length are held in registers so they stay stable while xVALID waits
    assign AWADDR  = addr_q;
    assign AWLEN   = len_q;
    assign AWSIZE  = AXSIZE;
    assign AWVALID = (state == S_AW);
    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = AXSIZE;
    assign ARVALID = (state == S_AR);

    // write beats pass straight through; gated by state so no W leaks before AW
    assign WDATA    = wr_data;
    assign WVALID   = (state == S_W) & wr_valid;
    assign WLAST    = (state == S_W) & beat_at_len;
    assign wr_ready = (state == S_W) & WREADY;
    assign BREADY   = (state == S_B);

    assign rd_data  = RDATA;
    assign rd_valid = (state == S_R) & RVALID;
    assign rd_last  = (state == S_R) & RLAST;
    assign RREADY   = (state == S_R) & rd_ready;

    assign cmd_ready = (state == S_IDLE);
    assign done      = (state == S_DONE);

    // burst sequencing, beat counting and completion status capture
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            beat    <= '0;
            racc    <= 2'b00;
            over_q  <= 1'b0;
            resp    <= 2'b00;
            len_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q <= cmd_addr;
                        len_q  <= cmd_len;
                        beat   <= '0;
                        racc   <= 2'b00;
                        over_q <= 1'b0;
`ifdef BOUNDARY_CHECK_EN
                        if (crosses_4k) begin
                            state   <= S_DONE;
                            resp    <= 2'b10;
                            len_err <= 1'b0;
                        end else begin
                            state <= cmd_write ? S_AW : S_AR;
                        end
`else
                        state <= cmd_write ? S_AW : S_AR;
`endif
                    end
                end
                S_AW: begin
                    if (AWREADY) state <= S_W;
                end
                S_W: begin
                    if (w_fire) begin
                        if (beat_at_len) state <= S_B;
                        else             beat  <= beat + LEN_W'(1);
                    end
                end
                S_B: begin
                    if (BVALID) begin
                        resp    <= BRESP;
                        len_err <= 1'b0;
                        state   <= S_DONE;
                    end
                end
                S_AR: begin
                    if (ARREADY) state <= S_R;
                end
                S_R: begin
                    if (r_fire) begin
                        racc <= rresp_max;
                        if (RLAST) begin
                            resp    <= rresp_max;
                            len_err <= over_q | ~beat_at_len;
                            state   <= S_DONE;
                        end else begin
                            // slave overran the requested length: keep draining, remember it
                            if (beat_at_len) over_q <= 1'b1;
                            if (beat != '1)  beat   <= beat + LEN_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
